// File: rtl/iter_mac_pkg.sv
// Shared types and helpers for the iterative MAC.
//   state_e      : top-level sequencing states
//   count_w()    : width of a counter that holds 0..w
//   sat_max/min  : clamp limits for an aw-bit accumulator, signed or unsigned.
//                  They return a wide vector; callers take the low aw bits.
package iter_mac_pkg;

  typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_e;

  localparam int SAT_W = 128;

  function automatic int count_w(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_max(input int aw, input logic sgn);
    logic [SAT_W-1:0] one;
    one = SAT_W'(1);
    return sgn ? ((one << (aw - 1)) - one) : ((one << aw) - one);
  endfunction

  function automatic logic [SAT_W-1:0] sat_min(input int aw, input logic sgn);
    logic [SAT_W-1:0] one;
    one = SAT_W'(1);
    return sgn ? (one << (aw - 1)) : '0;
  endfunction

endpackage

// File: rtl/iter_mul_core.sv
// Radix-2 shift-add magnitude multiplier, one multiplier bit per cycle.
//   clk, rst       : clock, synchronous active-high reset
//   start          : load mcand/mplier (ignored while busy)
//   mcand, mplier  : unsigned WIDTH-bit magnitudes
//   busy           : iteration in progress
//   done           : high during the final iteration; product is complete
//                    after this edge
//   product        : unsigned 2*WIDTH-bit result, held until next start
module iter_mul_core
  import iter_mac_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = count_w(WIDTH);

  logic [2*WIDTH-1:0] mc_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mp_q;
  logic [CW-1:0]      cnt_q;

  assign busy    = (cnt_q != '0);
  assign done    = (cnt_q == CW'(1));
  assign product = prod_q;

  // Full 2*WIDTH partial product: (2^W-1)^2 never carries out, and the
  // -2^(W-1) magnitude (2^(W-1)) still fits the unsigned WIDTH-bit operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      mc_q   <= '0;
      mp_q   <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
    end else if (start && !busy) begin
      mc_q   <= {{WIDTH{1'b0}}, mcand};
      mp_q   <= mplier;
      prod_q <= '0;
      cnt_q  <= CW'(WIDTH);
    end else if (busy) begin
      if (mp_q[0]) prod_q <= prod_q + mc_q;
      mc_q  <= mc_q << 1;
      mp_q  <= mp_q >> 1;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/iter_mac_param.sv
// Iterative multiply-accumulate with valid/ready on both sides.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid/in_ready, a, b, signed_mode, last : operand-pair input;
//                   signed_mode is taken from the first term of a sequence
//   out_valid/out_ready, acc_out, overflow     : sequence result; overflow
//                   is sticky across the sequence
// Per term: 1 accept cycle, WIDTH multiply cycles, 1 accumulate cycle.
module iter_mac_param
  import iter_mac_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  input  logic                 last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 overflow
);

  localparam logic [ACC_WIDTH-1:0] MAX_S = ACC_WIDTH'(sat_max(ACC_WIDTH, 1'b1));
  localparam logic [ACC_WIDTH-1:0] MIN_S = ACC_WIDTH'(sat_min(ACC_WIDTH, 1'b1));
  localparam logic [ACC_WIDTH-1:0] MAX_U = ACC_WIDTH'(sat_max(ACC_WIDTH, 1'b0));

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 ovf_q;
  logic                 first_q;   // next accepted term opens a sequence
  logic                 mode_q;    // signed_mode latched for the sequence
  logic                 sign_q;    // product sign of the current term
  logic                 last_q;

  logic                 mode_eff;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 accept;
  logic                 core_busy, core_done;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_s;
  logic [ACC_WIDTH-1:0] term;
  logic [ACC_WIDTH:0]   sum_w;
  logic                 ovf_now;
  logic [ACC_WIDTH-1:0] clamp;
  logic [ACC_WIDTH-1:0] acc_next;

  // Mode comes from the live pin only on the first term; later terms reuse it.
  assign mode_eff = first_q ? signed_mode : mode_q;
  assign mag_a    = (mode_eff && a[WIDTH-1]) ? -a : a;
  assign mag_b    = (mode_eff && b[WIDTH-1]) ? -b : b;
  assign accept   = in_valid && in_ready;

  iter_mul_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .mcand  (mag_a),
    .mplier (mag_b),
    .busy   (core_busy),
    .done   (core_done),
    .product(prod)
  );

  // Signed magnitude never exceeds 2^(2W-2), so negation in 2W bits is exact.
  assign prod_s = sign_q ? -prod : prod;
  assign term   = mode_q ? ACC_WIDTH'($signed(prod_s)) : ACC_WIDTH'(prod_s);
  assign sum_w  = {1'b0, acc_q} + {1'b0, term};

  assign ovf_now = mode_q
    ? ((acc_q[ACC_WIDTH-1] == term[ACC_WIDTH-1]) &&
       (sum_w[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
    : sum_w[ACC_WIDTH];

  // Signed overflow direction follows the common operand sign.
  assign clamp    = mode_q ? (acc_q[ACC_WIDTH-1] ? MIN_S : MAX_S) : MAX_U;
  assign acc_next = ((SATURATE != 0) && ovf_now) ? clamp : sum_w[ACC_WIDTH-1:0];

  assign acc_out  = acc_q;
  assign overflow = ovf_q;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !core_busy;
        if (in_valid && !core_busy) state_d = MUL;
      end
      MUL:  if (core_done) state_d = ACC;
      ACC:  state_d = last_q ? OUT : IDLE;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
      mode_q  <= 1'b0;
      sign_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          sign_q <= mode_eff & (a[WIDTH-1] ^ b[WIDTH-1]);
          last_q <= last;
          if (first_q) begin
            mode_q  <= signed_mode;
            first_q <= 1'b0;
          end
        end
        ACC: begin
          acc_q <= acc_next;
          if (ovf_now) ovf_q <= 1'b1;
        end
        OUT: if (out_ready) begin
          acc_q   <= '0;
          ovf_q   <= 1'b0;
          first_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_mac_param.sv
// Three instances share one stimulus stream: 24-bit wrap, 16-bit saturate,
// 16-bit wrap. Expected sums come from integer arithmetic on the real values.
module tb_iter_mac_param;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, signed_mode = 1'b0, last = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2;
  logic [23:0] acc0;
  logic [15:0] acc1, acc2;

  iter_mac_param #(.WIDTH(W), .ACC_WIDTH(24), .SATURATE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b),
    .signed_mode(signed_mode), .last(last), .out_valid(ov0), .out_ready(out_ready),
    .acc_out(acc0), .overflow(of0));
  iter_mac_param #(.WIDTH(W), .ACC_WIDTH(16), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
    .signed_mode(signed_mode), .last(last), .out_valid(ov1), .out_ready(out_ready),
    .acc_out(acc1), .overflow(of1));
  iter_mac_param #(.WIDTH(W), .ACC_WIDTH(16), .SATURATE(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .a(a), .b(b),
    .signed_mode(signed_mode), .last(last), .out_valid(ov2), .out_ready(out_ready),
    .acc_out(acc2), .overflow(of2));

  typedef struct {
    logic [23:0] e0;
    logic [15:0] e1, e2;
    bit o0, o1, o2;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int checks = 0, errors = 0, cyc = 0;
  bit hold = 1'b1, seen = 1'b0;
  logic [23:0] last0;
  logic [15:0] last1, last2;
  logic lof0, lof1, lof2;

  // reference model state
  bit m_first = 1'b1, m_sm = 1'b0;
  longint m_acc[3];
  bit m_ovf[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void mstep(input int aw, input bit sat, input bit sm, input longint p,
                                inout longint acc, inout bit ovf);
    longint s, hi, lo, span;
    span = longint'(1) << aw;
    hi = sm ? (span / 2) - 1 : span - 1;
    lo = sm ? -(span / 2) : 0;
    s = acc + p;
    if (s > hi) begin ovf = 1'b1; acc = sat ? hi : s - span; end
    else if (s < lo) begin ovf = 1'b1; acc = sat ? lo : s + span; end
    else acc = s;
  endfunction

  function automatic void mreset();
    m_first = 1'b1;
    for (int i = 0; i < 3; i++) begin m_acc[i] = 0; m_ovf[i] = 1'b0; end
  endfunction

  task automatic model_term(input logic [W-1:0] ta, tb, input bit tsm, tl, input int k);
    int av, bv;
    longint p;
    exp_t e;
    if (m_first) begin m_sm = tsm; m_first = 1'b0; end
    av = m_sm ? int'($signed(ta)) : int'(ta);
    bv = m_sm ? int'($signed(tb)) : int'(tb);
    p = longint'(av) * longint'(bv);
    mstep(24, 1'b0, m_sm, p, m_acc[0], m_ovf[0]);
    mstep(16, 1'b1, m_sm, p, m_acc[1], m_ovf[1]);
    mstep(16, 1'b0, m_sm, p, m_acc[2], m_ovf[2]);
    if (tl) begin
      e.e0 = 24'(m_acc[0]); e.e1 = 16'(m_acc[1]); e.e2 = 16'(m_acc[2]);
      e.o0 = m_ovf[0]; e.o1 = m_ovf[1]; e.o2 = m_ovf[2];
      e.cyc = k + W + 1;  // OUT registered at edge k+W+1, consumable at k+W+2
      sb.push_back(e);
      mreset();
    end
  endtask

  // ng: cycles of junk on the input pins while the term multiplies
  task automatic send(input logic [W-1:0] ta, tb, input bit tsm, tl, input int ng);
    int t = 0;
    @(negedge clk);
    a = ta; b = tb; signed_mode = tsm; last = tl; in_valid = 1'b1;
    while (!ir0 && t < 300) begin @(negedge clk); t++; end
    if (!ir0) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready stuck low");
      in_valid = 1'b0;
    end else begin
      model_term(ta, tb, tsm, tl, cyc + 1);
      @(negedge clk);
      for (int i = 0; i < ng; i++) begin
        a = W'($urandom); b = W'($urandom); in_valid = 1'($urandom);
        last = 1'($urandom); signed_mode = 1'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || ov0) && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending %0d out_valid %0b", sb.size(), ov0);
    end
  endtask

  // consumer
  initial forever begin
    @(negedge clk);
    out_ready = hold ? 1'b0 : ($urandom_range(0, 2) == 0);
  end

  // monitor
  initial forever begin
    @(negedge clk);
    if (rst) seen = 1'b0;
    else if (ov0) begin
      if (!seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result acc %0h", acc0);
        end else begin
          cur = sb.pop_front();
          chk("latency", cyc, cur.cyc);
          chk("acc24", acc0, cur.e0);  chk("ovf24", of0, cur.o0);
          chk("acc16s", acc1, cur.e1); chk("ovf16s", of1, cur.o1);
          chk("acc16w", acc2, cur.e2); chk("ovf16w", of2, cur.o2);
          chk("valid_align", {ov1, ov2}, 2'b11);
        end
        last0 = acc0; last1 = acc1; last2 = acc2;
        lof0 = of0; lof1 = of1; lof2 = of2;
      end else begin
        chk("hold_acc", acc0, cur.e0);
        chk("hold_in_ready", ir0, 1'b0);
      end
    end else seen = 1'b0;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    mreset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", ir0, 1'b1); chk("rst_out_valid", ov0, 1'b0);
    chk("rst_acc", acc0, 24'd0);    chk("rst_ovf", of0, 1'b0);
    hold = 1'b0;

    // single unsigned term
    send(8'd3, 8'd5, 1'b0, 1'b1, W); drain();
    chk("t1_acc", last0, 24'd15); chk("t1_ovf", lof0, 1'b0);

    // signed corner -128*-128 plus 127*-1
    send(8'h80, 8'h80, 1'b1, 1'b0, W);
    send(8'd127, 8'hFF, 1'b1, 1'b1, W); drain();
    chk("t2_acc", last0, 24'h003F81); chk("t2_ovf", lof0, 1'b0);

    // three 127*127 signed terms in 16 bits
    for (int i = 0; i < 3; i++) send(8'd127, 8'd127, 1'b1, (i == 2), W);
    drain();
    chk("t3_sat_acc", last1, 16'h7FFF); chk("t3_sat_ovf", lof1, 1'b1);
    chk("t3_wrap_acc", last2, 16'hBD03); chk("t3_wrap_ovf", lof2, 1'b1);
    chk("t3_wide_acc", last0, 24'd48387);

    // backpressure
    hold = 1'b1;
    send(8'd9, 8'd9, 1'b0, 1'b1, W);
    for (int t = 0; t < 40 && !ov0; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("t4_valid_held", ov0, 1'b1); chk("t4_in_ready", ir0, 1'b0);
    chk("t4_acc_held", acc0, 24'd81);
    hold = 1'b0; drain();
    send(8'd2, 8'd2, 1'b0, 1'b1, W); drain();
    chk("t4_cleared", last0, 24'd4);

    // reset in MUL cycle 4
    send(8'd100, 8'd100, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete(); mreset();
    chk("t5_in_ready", ir0, 1'b1); chk("t5_out_valid", ov0, 1'b0);
    chk("t5_acc", acc0, 24'd0);    chk("t5_ovf", of0, 1'b0);
    send(8'd6, 8'd7, 1'b0, 1'b1, W); drain();
    chk("t5_acc_after", last0, 24'd42);

    // mode flip on second term ignored
    send(8'd200, 8'd2, 1'b0, 1'b0, W);
    send(8'd255, 8'd1, 1'b1, 1'b1, W); drain();
    chk("t6_acc", last0, 24'd655);

    // random sequences
    for (int s = 0; s < 40; s++) begin
      int len;
      bit sm;
      len = $urandom_range(1, 4);
      sm = 1'($urandom);
      for (int i = 0; i < len; i++)
        send(W'($urandom), W'($urandom), (i == 0) ? sm : 1'($urandom),
             (i == len - 1), $urandom_range(0, W));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
